// File: rtl/sha1_stream_pkg.sv
// rtl/sha1_stream_pkg.sv - shared widths and beat type for the SHA-1 message path
package sha1_stream_pkg;
  localparam int IN_BYTES  = 4;
  localparam int OUT_BYTES = 64;
  localparam int WORDS     = OUT_BYTES / IN_BYTES;
  localparam int IDX_W     = $clog2(WORDS);
  localparam int IN_W      = 8 * IN_BYTES;
  localparam int OUT_W     = 8 * OUT_BYTES;

  typedef struct packed {
    logic [OUT_W-1:0]     data;
    logic [OUT_BYTES-1:0] keep;
    logic                 last;
  } beat_t;
endpackage

// File: rtl/sha1_stream_packer_if.sv
// rtl/sha1_stream_packer_if.sv - word-in / beat-out stream bundle for the packer
interface sha1_stream_packer_if;
  import sha1_stream_pkg::*;

  logic                 o_tready_in;
  logic                 i_tvalid_in;
  logic [IN_W-1:0]      i_tdata_in;
  logic [IN_BYTES-1:0]  i_tkeep_in;
  logic                 i_tlast_in;
  logic                 i_tready_out;
  logic                 o_tvalid_out;
  logic [OUT_W-1:0]     o_tdata_out;
  logic [OUT_BYTES-1:0] o_tkeep_out;
  logic                 o_tlast_out;

  modport master (
    output i_tvalid_in, i_tdata_in, i_tkeep_in, i_tlast_in, i_tready_out,
    input  o_tready_in, o_tvalid_out, o_tdata_out, o_tkeep_out, o_tlast_out
  );

  modport slave (
    input  i_tvalid_in, i_tdata_in, i_tkeep_in, i_tlast_in, i_tready_out,
    output o_tready_in, o_tvalid_out, o_tdata_out, o_tkeep_out, o_tlast_out
  );
endinterface

// File: rtl/sha1_beat_slot.sv
// rtl/sha1_beat_slot.sv - single-entry valid/ready beat register that holds on stall
module sha1_beat_slot
  import sha1_stream_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_load,
  input  beat_t i_beat,
  input  logic  i_ready,
  output logic  o_valid,
  output beat_t o_beat
);
  logic  r_valid;
  beat_t r_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_beat  <= i_beat;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_beat  = r_beat;
endmodule

// File: rtl/sha1_stream_packer.sv
// rtl/sha1_stream_packer.sv - packs 32-bit words with keeps into 512-bit SHA-1 beats
module sha1_stream_packer
  import sha1_stream_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  sha1_stream_packer_if.slave s
);
  logic [OUT_W-1:0]     r_data,  w_data_nxt;
  logic [OUT_BYTES-1:0] r_keep,  w_keep_nxt;
  logic [IDX_W-1:0]     r_idx,   w_idx_nxt, w_base_idx;
  logic                 r_acc_done, w_done_nxt;
  logic                 r_acc_last, w_last_nxt;
  logic                 w_slot_valid, w_slot_free, w_xfer, w_accept, w_tready_in;
  logic [IN_BYTES-1:0]  w_wkeep;
  logic [IN_W-1:0]      w_wdata;
  beat_t                w_acc_beat, w_slot_beat;

  assign w_slot_free = !w_slot_valid || s.i_tready_out;
  assign w_xfer      = r_acc_done && w_slot_free;
  assign w_tready_in = !reset && (!r_acc_done || w_slot_free);
  assign w_accept    = s.i_tvalid_in && w_tready_in;
  // A transfer clears the accumulator, so a word arriving alongside lands at lane 0
  assign w_base_idx  = w_xfer ? '0 : r_idx;
  assign w_wkeep     = s.i_tlast_in ? s.i_tkeep_in : '1;

  // Disabled bytes are zeroed so unused lanes of a beat read as 0
  always_comb begin
    w_wdata = '0;
    for (int b = 0; b < IN_BYTES; b++) begin
      if (w_wkeep[b]) w_wdata[8*b +: 8] = s.i_tdata_in[8*b +: 8];
    end
  end

  always_comb begin
    w_data_nxt = w_xfer ? '0 : r_data;
    w_keep_nxt = w_xfer ? '0 : r_keep;
    w_idx_nxt  = w_base_idx;
    w_done_nxt = w_xfer ? 1'b0 : r_acc_done;
    w_last_nxt = w_xfer ? 1'b0 : r_acc_last;
    if (w_accept) begin
      w_data_nxt[IN_W*w_base_idx +: IN_W]         = w_wdata;
      w_keep_nxt[IN_BYTES*w_base_idx +: IN_BYTES] = w_wkeep;
      w_idx_nxt = w_base_idx + 1'b1;
      if (s.i_tlast_in) begin
        w_done_nxt = 1'b1;
        w_last_nxt = 1'b1;
      end else if (w_base_idx == IDX_W'(WORDS-1)) begin
        w_done_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data     <= '0;
      r_keep     <= '0;
      r_idx      <= '0;
      r_acc_done <= 1'b0;
      r_acc_last <= 1'b0;
    end else begin
      r_data     <= w_data_nxt;
      r_keep     <= w_keep_nxt;
      r_idx      <= w_idx_nxt;
      r_acc_done <= w_done_nxt;
      r_acc_last <= w_last_nxt;
    end
  end

  assign w_acc_beat = '{data: r_data, keep: r_keep, last: r_acc_last};

  sha1_beat_slot u_slot (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_xfer),
    .i_beat  (w_acc_beat),
    .i_ready (s.i_tready_out),
    .o_valid (w_slot_valid),
    .o_beat  (w_slot_beat)
  );

  assign s.o_tready_in  = w_tready_in;
  assign s.o_tvalid_out = w_slot_valid;
  assign s.o_tdata_out  = w_slot_beat.data;
  assign s.o_tkeep_out  = w_slot_beat.keep;
  assign s.o_tlast_out  = w_slot_beat.last;
endmodule

// File: tb/tb_sha1_stream_packer.sv
// tb/tb_sha1_stream_packer.sv - directed table-driven bench for sha1_stream_packer
module tb_sha1_stream_packer;
  import sha1_stream_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  sha1_stream_packer_if bus ();

  sha1_stream_packer dut (.clk(clk), .reset(reset), .s(bus.slave));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  beat_t q[$];

  typedef struct {
    int          nwords;
    logic [3:0]  lkeep;
    int          nbeats;
    logic [63:0] keep0;
    logic        last0;
    logic [63:0] keep1;
    logic        last1;
  } vec_t;

  vec_t vecs[7];

  // Beats are captured one time unit before the edge that completes the handshake
  always @(negedge clk) begin
    #4;
    if (!reset && bus.o_tvalid_out && bus.i_tready_out)
      q.push_back('{data: bus.o_tdata_out, keep: bus.o_tkeep_out, last: bus.o_tlast_out});
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_data(input int b, input logic [63:0] keep);
    logic [511:0] d;
    d = '0;
    for (int j = 0; j < 64; j++)
      if (keep[j]) d[8*j +: 8] = 8'((b*64 + j) & 255);
    return d;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    int guard;
    bus.i_tvalid_in = 1'b1;
    bus.i_tdata_in  = d;
    bus.i_tkeep_in  = k;
    bus.i_tlast_in  = l;
    guard = 0;
    #1;
    while (!bus.o_tready_in) begin
      if (guard == 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: o_tready_in stuck at 0, required 1 within 300 cycles");
        break;
      end
      @(negedge clk);
      #1;
      guard++;
    end
    @(negedge clk);
    bus.i_tvalid_in = 1'b0;
    bus.i_tlast_in  = 1'b0;
  endtask

  task automatic send_msg(input int n, input logic [3:0] lk);
    logic [7:0] b;
    for (int w = 0; w < n; w++) begin
      b = 8'(4*w);
      send_word({b + 8'd3, b + 8'd2, b + 8'd1, b}, (w == n-1) ? lk : 4'h5, w == n-1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [576:0] snap, cur;
    bit seen, stable;
    logic [7:0] b;

    vecs[0] = '{16, 4'hF, 1, '1,               1'b1, 64'h0,    1'b0};
    vecs[1] = '{3,  4'h3, 1, 64'h3FF,          1'b1, 64'h0,    1'b0};
    vecs[2] = '{20, 4'hF, 2, '1,               1'b0, 64'hFFFF, 1'b1};
    vecs[3] = '{17, 4'h0, 2, '1,               1'b0, 64'h0,    1'b1};
    vecs[4] = '{1,  4'h0, 1, 64'h0,            1'b1, 64'h0,    1'b0};
    vecs[5] = '{5,  4'h7, 1, 64'h7_FFFF,       1'b1, 64'h0,    1'b0};
    vecs[6] = '{1,  4'h1, 1, 64'h1,            1'b1, 64'h0,    1'b0};

    bus.i_tvalid_in  = 1'b0;
    bus.i_tdata_in   = '0;
    bus.i_tkeep_in   = '0;
    bus.i_tlast_in   = 1'b0;
    bus.i_tready_out = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_tready_in", 512'(bus.o_tready_in), 512'(0));
    check("rst_tvalid",    512'(bus.o_tvalid_out), 512'(0));
    check("rst_tdata",     bus.o_tdata_out, '0);
    check("rst_tkeep",     512'(bus.o_tkeep_out), 512'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_tready_in", 512'(bus.o_tready_in), 512'(1));
    @(negedge clk);

    // Latency: beat valid one edge after the completing word is accepted
    q.delete();
    send_msg(16, 4'hF);
    check("lat_not_yet", 512'(bus.o_tvalid_out), 512'(0));
    @(negedge clk);
    #1;
    check("lat_valid", 512'(bus.o_tvalid_out), 512'(1));
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("lat_count", 512'(q.size()), 512'(1));

    foreach (vecs[i]) begin
      q.delete();
      send_msg(vecs[i].nwords, vecs[i].lkeep);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_count", i), 512'(q.size()), 512'(vecs[i].nbeats));
      for (int bb = 0; bb < vecs[i].nbeats && bb < q.size(); bb++) begin
        check($sformatf("v%0d_b%0d_keep", i, bb), 512'(q[bb].keep),
              512'(bb == 0 ? vecs[i].keep0 : vecs[i].keep1));
        check($sformatf("v%0d_b%0d_last", i, bb), 512'(q[bb].last),
              512'(bb == 0 ? vecs[i].last0 : vecs[i].last1));
        check($sformatf("v%0d_b%0d_data", i, bb), q[bb].data,
              exp_data(bb, bb == 0 ? vecs[i].keep0 : vecs[i].keep1));
      end
    end

    // Backpressure: 32-word message with downstream stalled for 40 cycles
    q.delete();
    bus.i_tready_out = 1'b0;
    seen = 1'b0;
    stable = 1'b1;
    snap = '0;
    fork
      send_msg(32, 4'hF);
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          #1;
          if (bus.o_tvalid_out) begin
            cur = {bus.o_tdata_out, bus.o_tkeep_out, bus.o_tlast_out};
            if (!seen) begin
              snap = cur;
              seen = 1'b1;
            end else if (cur !== snap) begin
              stable = 1'b0;
            end
          end
        end
        check("stall_seen",      512'(seen), 512'(1));
        check("stall_stable",    512'(stable), 512'(1));
        check("stall_tready_in", 512'(bus.o_tready_in), 512'(0));
        check("stall_tvalid",    512'(bus.o_tvalid_out), 512'(1));
        @(negedge clk);
        bus.i_tready_out = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    check("bp_count", 512'(q.size()), 512'(2));
    for (int bb = 0; bb < 2 && bb < q.size(); bb++) begin
      check($sformatf("bp_b%0d_keep", bb), 512'(q[bb].keep), 512'({64{1'b1}}));
      check($sformatf("bp_b%0d_last", bb), 512'(q[bb].last), 512'(bb == 1));
      check($sformatf("bp_b%0d_data", bb), q[bb].data, exp_data(bb, '1));
    end

    // Reset mid-packet with a stalled beat pending in the slot
    bus.i_tready_out = 1'b0;
    send_msg(16, 4'hF);
    for (int w = 0; w < 7; w++) begin
      b = 8'(4*w);
      send_word({b + 8'd3, b + 8'd2, b + 8'd1, b}, 4'hF, 1'b0);
    end
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_tvalid",   512'(bus.o_tvalid_out), 512'(0));
    check("mid_rst_tdata",    bus.o_tdata_out, '0);
    check("mid_rst_tkeep",    512'(bus.o_tkeep_out), 512'(0));
    check("mid_rst_tlast",    512'(bus.o_tlast_out), 512'(0));
    check("mid_rst_tready",   512'(bus.o_tready_in), 512'(0));
    @(negedge clk);
    reset = 1'b0;
    bus.i_tready_out = 1'b1;
    #1;
    check("mid_rel_tready", 512'(bus.o_tready_in), 512'(1));
    @(negedge clk);
    q.delete();
    send_msg(16, 4'hF);
    repeat (4) @(negedge clk);
    check("post_rst_count", 512'(q.size()), 512'(1));
    if (q.size() > 0) begin
      check("post_rst_keep", 512'(q[0].keep), 512'({64{1'b1}}));
      check("post_rst_last", 512'(q[0].last), 512'(1));
      check("post_rst_data", q[0].data, exp_data(0, '1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sha1_stream_packer.md
# sha1_stream_packer

Narrow-to-wide AXI-stream packer that feeds the SHA-1 message path. Accepts a message as 32-bit words with byte keeps and assembles 512-bit beats with a 64-bit byte keep and packet end flag. These beats are in exactly the form the SHA-1 alignment/padding stage consumes. Sits between the host/bus-side word interface and the 512-bit alignment input.

## Interface
- IN_BYTES, 4, input word width in bytes.
- OUT_BYTES, 64, output beat width in bytes; must be an integer multiple of IN_BYTES. Derived: WORDS = OUT_BYTES/IN_BYTES = 16.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- o_tready_in  out  1  input ready.
- i_tvalid_in  in  1  input word valid.
- i_tdata_in  in  8*IN_BYTES  input word; byte b occupies bits [8b+7:8b].
- i_tkeep_in  in  IN_BYTES  byte enables; only meaningful on the last word.
- i_tlast_in  in  1  last word of message.
- i_tready_out  in  1  downstream ready.
- o_tvalid_out  out  1  output beat valid.
- o_tdata_out  out  8*OUT_BYTES  assembled beat.
- o_tkeep_out  out  OUT_BYTES  byte enables of the beat.
- o_tlast_out  out  1  beat carries message end.

## Operation
- Two storage stages:
  - accumulator: data, keep, word index `idx` (0..WORDS-1), `acc_done`, `acc_last`;
  - output slot: drives the o_* signals.
- Word placement: the word accepted at index k goes to data bits [32k+31:32k] and keep bits [4k+3:4k]. Ascending lane order is message byte order.
- Accepted word, non-last:
  - its keep is forced to all-ones regardless of i_tkeep_in;
  - `idx` increments;
  - on idx = WORDS-1, set `acc_done`; `acc_last` = 0.
- Accepted word with i_tlast_in:
  - keep = i_tkeep_in. Legal values are 0, 1, 3, 7 and F (contiguous from the LSB); other values are passed through unchecked.
  - Set `acc_done` and `acc_last`, whatever `idx` is.
- Unwritten lanes of a beat carry data 0 and keep 0.
- Zero-length tail: tlast with keep 0 as the first word of a beat emits a beat with o_tkeep_out all zero and o_tlast_out = 1.
- Transfer: when `acc_done` and the slot is free, move the accumulator to the slot.
  - Slot free = !o_tvalid_out || i_tready_out.
  - On transfer, clear the accumulator (data/keep to 0, `idx` to 0, flags to 0).
- o_tready_in = !reset && (!acc_done || slot free). This is combinational from i_tready_out.
- Simultaneous transfer and new input word: the new word is written at index 0 of the cleared accumulator in the same cycle. No word is lost and no bubble is inserted.
- Slot update: slot loads on transfer; otherwise o_tvalid_out clears on a handshake (o_tvalid_out && i_tready_out).
- While o_tvalid_out = 1 and i_tready_out = 0, all o_* outputs hold stable.

## Timing
- Reset (async assert, synchronous release):
  - o_tvalid_out, o_tdata_out, o_tkeep_out, o_tlast_out = 0;
  - accumulator cleared, `idx` = 0;
  - o_tready_in = 0 while reset is high, 1 on the first cycle after release.
- Latency: the word completing a beat is accepted at edge N and the beat is valid after edge N+1, provided the slot is free.
- Throughput: 1 input word per cycle sustained while downstream accepts at least one beat per WORDS cycles. The output is never back-to-back except after short (tlast) beats.
- Backpressure: with the slot full and stalled and `acc_done` = 1, o_tready_in = 0 until a downstream handshake.
- Reset mid-packet discards the partial accumulator and any pending output beat. There is no recovery of the lost data.

## Structure
- Shared package `sha1_stream_pkg`: IN_BYTES/OUT_BYTES defaults, WORDS, and the beat struct typedef (data, keep, last). This package is shared with the alignment and padding stage.
- One sub-module is natural: `sha1_beat_slot`, a single-entry valid/ready output register with hold-on-stall, reused elsewhere in the SHA path. The accumulator stays in the top.

## Test plan
- 16 consecutive words 0x03020100, 0x07060504, …, tlast on the 16th, i_tready_out = 1 → one beat with o_tdata_out bytes 0..63 = 0x00..0x3F, o_tkeep_out all ones, o_tlast_out = 1, valid after edge N+1.
- 3-word message, last tkeep = 4'h3 → beat keep = 64'h0000_0000_0000_03FF, data bits above 79 = 0, tlast = 1.
- 20-word message, last tkeep = F → first beat full with tlast = 0, second beat keep = 64'hFFFF with tlast = 1.
- Zero-length tail (first word of beat, tlast, tkeep = 0) → beat keep = 0, tlast = 1.
- Full beat with i_tready_out held 0 for 40 cycles while input is continuously valid:
  - the second beat completes; then o_tready_in = 0;
  - outputs are stable throughout;
  - on release, both beats arrive in order, no word is lost or duplicated.
- Assert reset mid-packet (after 7 words) → all outputs 0 immediately, o_tready_in = 0; after release, a fresh 16-word message yields exactly one correct beat.
